wb_pipe_reg: RTL and testbench
==============================

Name: wb_pipe_reg

Overview:
- Parametrised successor to the fixed MEM->WB register: a 2-entry elastic writeback pipeline stage with valid/ready handshakes on both sides.
- Carries one register-write packet per entry: destination address, data and write enable.
- Adds a skid entry so back-pressure never drops data, a flush, x0 write suppression, and combinational forwarding lookup ports for the ID/EX bypass network.
- Sits between MEM and register-file writeback.

Parameters:
DATA_W, 32, width of the write data
ADDR_W, 5, width of the register address
FWD_PORTS, 2, number of independent forwarding lookup ports
SKID_EN, 1, 1 = 2-entry (head + skid); 0 = single entry, up_ready_out = !head_valid || pop

Ports:
clk_in  in  1  clock, all state updates on rising edge
rst_in  in  1  synchronous reset, active-high
rdy_in  in  1  global ready; 0 freezes the block
flush_in  in  1  discard all held entries
up_valid_in  in  1  upstream packet valid
up_ready_out  out  1  block can accept a packet
up_addr_in  in  ADDR_W  destination register
up_data_in  in  DATA_W  write data
up_we_in  in  1  write enable
dn_valid_out  out  1  head entry valid
dn_ready_in  in  1  writeback consumes head
dn_addr_out  out  ADDR_W  head address
dn_data_out  out  DATA_W  head data
dn_we_out  out  1  head write enable
fwd_addr_in  in  FWD_PORTS*ADDR_W  lookup addresses; port k = bits [k*ADDR_W +: ADDR_W]
fwd_hit_out  out  FWD_PORTS  per-port hit
fwd_data_out  out  FWD_PORTS*DATA_W  per-port forwarded data
occupancy_out  out  2  held entries, 0..2

Behaviour:
- Storage: head (oldest) and skid (younger) entries, each holding {valid, addr, data, we}.
- Reset (rst_in=1 at a clock edge): both valids 0; addr, data and we 0.
  - Outputs after reset: dn_valid_out=0, dn_addr_out=0, dn_data_out=0, dn_we_out=0, occupancy_out=0, fwd_hit_out=0, fwd_data_out=0, up_ready_out=1 (if rdy_in=1).
- Priority: rst_in > flush_in > rdy_in gating > push/pop.
- rdy_in=0:
  - No state change.
  - up_ready_out=0 and dn_valid_out=0, so no handshake completes.
  - Forwarding outputs remain live.
- flush_in=1 (rdy_in ignored): both entries invalidated at the next edge. A same-cycle push is discarded and a same-cycle pop does not count.
- Signal definitions:
  - push = up_valid_in & up_ready_out
  - pop = dn_valid_out & dn_ready_in
  - up_ready_out = rdy_in & !skid_valid
- Capture rule: if up_addr_in==0, the stored we is forced to 0 (x0 writes suppressed); addr and data are stored unchanged.
- State transitions (H = head valid, S = skid valid):
  - EMPTY (H=0, S=0): push -> packet into head, ONE. Latency: packet visible on dn_* one cycle after the push edge.
  - ONE (H=1, S=0):
    - push & pop -> new packet to head, stay ONE.
    - push only -> packet to skid, FULL.
    - pop only -> EMPTY.
  - FULL (H=1, S=1): up_ready_out=0.
    - pop -> skid moves to head, ONE.
    - no pop -> hold.
- SKID_EN=0:
  - The skid entry is never written.
  - up_ready_out = rdy_in & (!head_valid | dn_ready_in).
  - Push with pop replaces the head.
- occupancy_out = H + S, registered state.
- Forwarding (combinational, per port k):
  - Hit if some valid entry has we=1 and addr == fwd_addr_k, with fwd_addr_k != 0.
  - When both entries match, the younger (skid) wins.
  - On miss: fwd_data=0, hit=0.
  - Forwarding reflects held state only; there is no bypass of up_* in the same cycle.
- Ordering: packets leave in arrival order; no packet is dropped or duplicated except by flush_in or reset.
- Reset mid-transfer: held packets are lost; the upstream handshake in that cycle is not completed.

Decomposition:
- Shared define package holds RstEnable, ZeroWorld, True/False, RegAddrBus and RegBus width macros; the block uses these for its defaults.
- One natural sub-module: wb_fwd_match, the per-port comparator and priority mux, instantiated FWD_PORTS times via generate.

Test Plan:
- Reset, then push {addr=5, data=0xDEADBEEF, we=1} with dn_ready_in=1 -> next cycle dn_valid_out=1, dn_addr_out=5, dn_data_out=0xDEADBEEF; cycle after, occupancy_out=0.
- Hold dn_ready_in=0 and push addr 3 then addr 4 -> occupancy_out=2, up_ready_out=0, a third push is stalled; release dn_ready_in -> outputs addr 3 then addr 4 in order.
- Head {7, 0x11, we=1} and skid {7, 0x22, we=1}, fwd_addr port0=7, port1=0 -> fwd_hit_out=2'b01, port0 data 0x22, port1 data 0.
- Push {addr=0, data=0x55, we=1} -> dn_we_out=0; a lookup of addr 0 gives no hit.
- FULL state with flush_in=1 plus simultaneous up_valid_in=1 -> next cycle occupancy_out=0, dn_valid_out=0; the pushed packet never appears.
- rdy_in=0 for 3 cycles while in ONE state with dn_ready_in=1 -> dn_valid_out=0 and state unchanged; on rdy_in=1 the held packet is delivered exactly once.

Source files
------------

// File: rtl/wb_pipe_reg_pkg.sv
// Shared definitions for the writeback pipeline register: reset polarity,
// boolean constants, default bus widths and the x0 capture helper.
package wb_pipe_reg_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic        True       = 1'b1;
    localparam logic        False      = 1'b0;
    localparam int          RegAddrBus = 5;
    localparam int          RegBus     = 32;
    localparam logic [31:0] ZeroWorld  = 32'h0000_0000;

    // Register x0 is hard-wired to zero, so a write aimed at it is dropped
    // at capture time; address and data are kept for observability.
    function automatic logic wb_capture_we(input logic addr_nonzero, input logic we);
        return we & addr_nonzero;
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// One forwarding lookup port: compares a lookup address against the two held
// entries and returns the youngest matching write.
module wb_fwd_match
    import wb_pipe_reg_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic              i_head_v,
    input  logic [ADDR_W-1:0] i_head_addr,
    input  logic [DATA_W-1:0] i_head_data,
    input  logic              i_head_we,
    input  logic              i_skid_v,
    input  logic [ADDR_W-1:0] i_skid_addr,
    input  logic [DATA_W-1:0] i_skid_data,
    input  logic              i_skid_we,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic w_head_m;
    logic w_skid_m;
    logic w_addr_nz;

    // Match each entry, then let the younger skid entry win over the head.
    always_comb begin
        w_addr_nz = |i_lookup_addr;
        w_head_m  = i_head_v & i_head_we & (i_head_addr == i_lookup_addr) & w_addr_nz;
        w_skid_m  = i_skid_v & i_skid_we & (i_skid_addr == i_lookup_addr) & w_addr_nz;
        o_hit     = w_head_m | w_skid_m;
        o_data    = DATA_W'(ZeroWorld);
        if (w_skid_m) begin
            o_data = i_skid_data;
        end else if (w_head_m) begin
            o_data = i_head_data;
        end
    end

endmodule

// File: rtl/wb_pipe_reg.sv
// Elastic MEM->WB register: head entry plus optional skid entry with
// valid/ready on both sides, flush, x0 suppression and forwarding lookups.
module wb_pipe_reg
    import wb_pipe_reg_pkg::*;
#(
    parameter int DATA_W    = RegBus,
    parameter int ADDR_W    = RegAddrBus,
    parameter int FWD_PORTS = 2,
    parameter int SKID_EN   = 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        flush_in,
    input  logic                        up_valid_in,
    output logic                        up_ready_out,
    input  logic [ADDR_W-1:0]           up_addr_in,
    input  logic [DATA_W-1:0]           up_data_in,
    input  logic                        up_we_in,
    output logic                        dn_valid_out,
    input  logic                        dn_ready_in,
    output logic [ADDR_W-1:0]           dn_addr_out,
    output logic [DATA_W-1:0]           dn_data_out,
    output logic                        dn_we_out,
    input  logic [FWD_PORTS*ADDR_W-1:0] fwd_addr_in,
    output logic [FWD_PORTS-1:0]        fwd_hit_out,
    output logic [FWD_PORTS*DATA_W-1:0] fwd_data_out,
    output logic [1:0]                  occupancy_out
);

    logic              r_head_v;
    logic [ADDR_W-1:0] r_head_addr;
    logic [DATA_W-1:0] r_head_data;
    logic              r_head_we;
    logic              r_skid_v;
    logic [ADDR_W-1:0] r_skid_addr;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_we;

    logic              w_up_ready;
    logic              w_dn_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_cap_we;

    // Handshake qualifiers; rdy_in low masks both sides so nothing transfers.
    always_comb begin
        if (SKID_EN != 0) begin
            w_up_ready = rdy_in & ~r_skid_v;
        end else begin
            w_up_ready = rdy_in & (~r_head_v | dn_ready_in);
        end
        w_dn_valid = rdy_in & r_head_v;
        w_push     = up_valid_in & w_up_ready;
        w_pop      = w_dn_valid & dn_ready_in;
        w_cap_we   = wb_capture_we(|up_addr_in, up_we_in);
    end

    // Entry storage: pop advances skid into head, push fills the first free slot.
    always_ff @(posedge clk_in) begin
        if (rst_in == RstEnable) begin
            r_head_v    <= False;
            r_head_addr <= '0;
            r_head_data <= DATA_W'(ZeroWorld);
            r_head_we   <= False;
            r_skid_v    <= False;
            r_skid_addr <= '0;
            r_skid_data <= DATA_W'(ZeroWorld);
            r_skid_we   <= False;
        end else if (flush_in) begin
            r_head_v <= False;
            r_skid_v <= False;
        end else begin
            if (w_pop) begin
                if (r_skid_v) begin
                    r_head_addr <= r_skid_addr;
                    r_head_data <= r_skid_data;
                    r_head_we   <= r_skid_we;
                    r_skid_v    <= False;
                end else begin
                    r_head_v <= False;
                end
            end
            if (w_push) begin
                if (!r_head_v || (w_pop && !r_skid_v)) begin
                    r_head_v    <= True;
                    r_head_addr <= up_addr_in;
                    r_head_data <= up_data_in;
                    r_head_we   <= w_cap_we;
                end else if (SKID_EN != 0) begin
                    r_skid_v    <= True;
                    r_skid_addr <= up_addr_in;
                    r_skid_data <= up_data_in;
                    r_skid_we   <= w_cap_we;
                end
            end
        end
    end

    assign up_ready_out  = w_up_ready;
    assign dn_valid_out  = w_dn_valid;
    assign dn_addr_out   = r_head_addr;
    assign dn_data_out   = r_head_data;
    assign dn_we_out     = r_head_we;
    assign occupancy_out = {1'b0, r_head_v} + {1'b0, r_skid_v};

    for (genvar k = 0; k < FWD_PORTS; k++) begin : g_fwd
        wb_fwd_match #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_match (
            .i_head_v      (r_head_v),
            .i_head_addr   (r_head_addr),
            .i_head_data   (r_head_data),
            .i_head_we     (r_head_we),
            .i_skid_v      (r_skid_v),
            .i_skid_addr   (r_skid_addr),
            .i_skid_data   (r_skid_data),
            .i_skid_we     (r_skid_we),
            .i_lookup_addr (fwd_addr_in[k*ADDR_W +: ADDR_W]),
            .o_hit         (fwd_hit_out[k]),
            .o_data        (fwd_data_out[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: directed scenarios followed by random traffic, all
// checked each cycle against a queue-based model of the stage.
module tb_wb_pipe_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;

    logic           clk = 1'b0;
    logic           rst, rdy, flush, up_valid, up_we, dn_ready;
    logic [AW-1:0]  up_addr;
    logic [DW-1:0]  up_data;
    logic [NP*AW-1:0] fwd_addr;
    logic           up_ready, dn_valid, dn_we;
    logic [AW-1:0]  dn_addr;
    logic [DW-1:0]  dn_data;
    logic [NP-1:0]  fwd_hit;
    logic [NP*DW-1:0] fwd_data;
    logic [1:0]     occ;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          we;
    } pkt_t;

    pkt_t q[$];
    bit   model_known = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wb_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .FWD_PORTS(NP), .SKID_EN(1)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rdy_in        (rdy),
        .flush_in      (flush),
        .up_valid_in   (up_valid),
        .up_ready_out  (up_ready),
        .up_addr_in    (up_addr),
        .up_data_in    (up_data),
        .up_we_in      (up_we),
        .dn_valid_out  (dn_valid),
        .dn_ready_in   (dn_ready),
        .dn_addr_out   (dn_addr),
        .dn_data_out   (dn_data),
        .dn_we_out     (dn_we),
        .fwd_addr_in   (fwd_addr),
        .fwd_hit_out   (fwd_hit),
        .fwd_data_out  (fwd_data),
        .occupancy_out (occ)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0; up_valid = 0; up_addr = '0;
        up_data = '0; up_we = 0; dn_ready = 0; fwd_addr = '0;
    endtask

    task automatic push_in(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        up_valid = 1; up_addr = a; up_data = d; up_we = we;
    endtask

    // Compare all outputs against the queue, then advance the queue by the
    // handshakes that will complete at the coming edge.
    task automatic model_cycle();
        bit exp_ur, exp_dv, hit;
        logic [AW-1:0] la;
        logic [DW-1:0] fd;
        pkt_t p;
        exp_ur = rdy && (q.size() < 2);
        exp_dv = rdy && (q.size() > 0);
        if (model_known) begin
            chk("up_ready", 64'(up_ready), 64'(exp_ur));
            chk("dn_valid", 64'(dn_valid), 64'(exp_dv));
            chk("occupancy", 64'(occ), 64'(q.size()));
            if (q.size() > 0) begin
                chk("dn_addr", 64'(dn_addr), 64'(q[0].a));
                chk("dn_data", 64'(dn_data), 64'(q[0].d));
                chk("dn_we", 64'(dn_we), 64'(q[0].we));
            end
            for (int k = 0; k < NP; k++) begin
                la = fwd_addr[k*AW +: AW];
                hit = 0;
                fd = '0;
                if (la != 0) begin
                    for (int i = 0; i < q.size(); i++) begin
                        if (q[i].we && q[i].a == la) begin
                            hit = 1;
                            fd = q[i].d;
                        end
                    end
                end
                chk("fwd_hit", 64'(fwd_hit[k]), 64'(hit));
                chk("fwd_data", 64'(fwd_data[k*DW +: DW]), 64'(fd));
            end
        end
        if (rst) begin
            q.delete();
            model_known = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (exp_dv && dn_ready) void'(q.pop_front());
            if (up_valid && exp_ur) begin
                p.a = up_addr;
                p.d = up_data;
                p.we = up_we && (up_addr != 0);
                q.push_back(p);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        idle();
        #1;
        chk("rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("rst_dn_addr", 64'(dn_addr), 64'd0);
        chk("rst_dn_data", 64'(dn_data), 64'd0);
        chk("rst_dn_we", 64'(dn_we), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        chk("rst_fwd_data", 64'(fwd_data), 64'd0);
        chk("rst_up_ready", 64'(up_ready), 64'd1);

        // single packet latency
        push_in(5, 32'hDEADBEEF, 1); dn_ready = 1;
        step();
        idle(); dn_ready = 1; #1;
        chk("t1_valid", 64'(dn_valid), 64'd1);
        chk("t1_addr", 64'(dn_addr), 64'd5);
        chk("t1_data", 64'(dn_data), 64'hDEADBEEF);
        step();
        idle(); #1;
        chk("t1_occ", 64'(occ), 64'd0);

        // back-pressure fills head and skid, third push stalls
        push_in(3, 32'h3333, 1); step();
        push_in(4, 32'h4444, 1); step();
        push_in(9, 32'h9999, 1); #1;
        chk("t2_occ", 64'(occ), 64'd2);
        chk("t2_up_ready", 64'(up_ready), 64'd0);
        step(); step();
        idle(); dn_ready = 1; #1;
        chk("t2_first", 64'(dn_addr), 64'd3);
        step();
        idle(); dn_ready = 1; #1;
        chk("t2_second", 64'(dn_addr), 64'd4);
        step();
        idle(); #1;
        chk("t2_empty", 64'(occ), 64'd0);

        // forwarding priority: skid beats head, lookup of x0 misses
        push_in(7, 32'h11, 1); step();
        push_in(7, 32'h22, 1); step();
        idle(); fwd_addr = {5'd0, 5'd7}; #1;
        chk("t3_hit", 64'(fwd_hit), 64'b01);
        chk("t3_data0", 64'(fwd_data[31:0]), 64'h22);
        chk("t3_data1", 64'(fwd_data[63:32]), 64'h0);
        step();
        idle(); dn_ready = 1; step(); step();

        // x0 write suppression
        idle(); push_in(0, 32'h55, 1); step();
        idle(); #1;
        chk("t4_valid", 64'(dn_valid), 64'd1);
        chk("t4_we", 64'(dn_we), 64'd0);
        chk("t4_hit", 64'(fwd_hit), 64'd0);
        step();
        idle(); dn_ready = 1; step();

        // flush from FULL with a simultaneous push
        idle(); push_in(10, 32'hA, 1); step();
        push_in(11, 32'hB, 1); step();
        idle(); flush = 1; push_in(12, 32'hC, 1); dn_ready = 1; step();
        idle(); #1;
        chk("t5_occ", 64'(occ), 64'd0);
        chk("t5_valid", 64'(dn_valid), 64'd0);
        step(); step();

        // rdy_in low freezes a held packet
        idle(); push_in(9, 32'h99, 1); step();
        for (int i = 0; i < 3; i++) begin
            idle(); rdy = 0; dn_ready = 1; #1;
            chk("t6_frozen_valid", 64'(dn_valid), 64'd0);
            chk("t6_frozen_occ", 64'(occ), 64'd1);
            step();
        end
        idle(); dn_ready = 1; #1;
        chk("t6_release", 64'(dn_valid), 64'd1);
        step();
        idle(); #1;
        chk("t6_once", 64'(occ), 64'd0);
        step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            rdy      = ($urandom_range(0, 9) != 0);
            up_valid = ($urandom_range(0, 9) < 6);
            up_addr  = AW'($urandom_range(0, 7));
            up_data  = $urandom;
            up_we    = ($urandom_range(0, 3) != 0);
            dn_ready = ($urandom_range(0, 1) == 1);
            fwd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
